// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Brief    : Per-register in-flight write counters with issue-stall logic.
// Revision : 1.0
// ============================================================================
module reg_scoreboard #(
  parameter int CNT_W     = 2,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic        issue_we,
  input  logic [4:0]  issue_dst,
  input  logic [4:0]  src_a,
  input  logic [4:0]  src_b,
  input  logic        wb_valid,
  input  logic [4:0]  wb_dst,
  input  logic        flush,
  output logic        stall,
  output logic        busy_a,
  output logic        busy_b,
  output logic [31:0] pending,
  output logic [7:0]  inflight,
  output logic        wb_err
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  // Entry 0 is reset and never updated, so it reads as zero everywhere.
  logic [CNT_W-1:0] r_cnt [32];
  logic [CNT_W-1:0] w_nxt [32];
  logic [31:0]      r_pending;
  logic [7:0]       r_inflight;
  logic             r_err;

  logic [CNT_W-1:0] w_cnt_a, w_cnt_b, w_cnt_d, w_cnt_w;
  logic             w_full, w_accept, w_wb_hit, w_same, w_err_set;
  logic [31:0]      w_pend;
  logic [7:0]       w_sum;

  assign w_cnt_a = r_cnt[src_a];
  assign w_cnt_b = r_cnt[src_b];
  assign w_cnt_d = r_cnt[issue_dst];
  assign w_cnt_w = r_cnt[wb_dst];

  // A retiring last write hides the hazard in the same cycle.
  assign busy_a = (w_cnt_a != '0) &&
                  !(WB_BYPASS && wb_valid && (wb_dst == src_a) && (w_cnt_a == c_cnt_one));
  assign busy_b = (w_cnt_b != '0) &&
                  !(WB_BYPASS && wb_valid && (wb_dst == src_b) && (w_cnt_b == c_cnt_one));

  assign w_full = issue_we && (issue_dst != 5'd0) && (w_cnt_d == c_cnt_max) &&
                  !(wb_valid && (wb_dst == issue_dst));
  assign stall  = issue_valid && (busy_a || busy_b || w_full);

  assign w_accept  = issue_valid && !stall && issue_we && (issue_dst != 5'd0);
  assign w_wb_hit  = wb_valid && (wb_dst != 5'd0);
  assign w_same    = w_accept && w_wb_hit && (issue_dst == wb_dst);
  assign w_err_set = w_wb_hit && (w_cnt_w == '0) && !w_same;

  always_comb begin
    w_sum  = '0;
    w_pend = '0;
    for (int i = 0; i < 32; i++) begin
      w_nxt[i] = r_cnt[i];
      if (i != 0) begin
        if (flush)
          w_nxt[i] = '0;
        else if (w_accept && (issue_dst == 5'(i)) && !(wb_valid && (wb_dst == 5'(i))))
          w_nxt[i] = r_cnt[i] + c_cnt_one;
        else if (wb_valid && (wb_dst == 5'(i)) && (r_cnt[i] != '0) &&
                 !(w_accept && (issue_dst == 5'(i))))
          w_nxt[i] = r_cnt[i] - c_cnt_one;
      end
      w_pend[i] = (w_nxt[i] != '0);
      w_sum     = w_sum + 8'(w_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
      r_pending  <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) r_cnt[i] <= w_nxt[i];
      r_pending  <= w_pend;
      r_inflight <= w_sum;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign pending  = r_pending;
  assign inflight = r_inflight;
  assign wb_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_scoreboard
// Brief    : Directed table, corner sequences and random run against a model.
// Revision : 1.0
// ============================================================================
module tb_reg_scoreboard;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_we, wb_valid, flush;
  logic [4:0]  issue_dst, src_a, src_b, wb_dst;
  logic        stall, busy_a, busy_b, wb_err;
  logic [31:0] pending;
  logic [7:0]  inflight;

  int total = 0;
  int bad   = 0;

  int cnt_m [32];
  bit err_m;

  reg_scoreboard #(.CNT_W(CNT_W), .WB_BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_dst(issue_dst),
    .src_a(src_a), .src_b(src_b),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .flush(flush),
    .stall(stall), .busy_a(busy_a), .busy_b(busy_b),
    .pending(pending), .inflight(inflight), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv, iwe;
    logic [4:0] dst, sa, sb;
    logic       wbv;
    logic [4:0] wbd;
    logic       fl;
    logic       e_stall, e_ba, e_bb;
    logic [31:0] e_pend;
    logic [7:0]  e_infl;
    logic        e_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic iwe, input logic [4:0] dst,
                       input logic [4:0] sa, input logic [4:0] sb,
                       input logic wbv, input logic [4:0] wbd, input logic fl);
    issue_valid = iv; issue_we = iwe; issue_dst = dst;
    src_a = sa; src_b = sb; wb_valid = wbv; wb_dst = wbd; flush = fl;
  endtask

  function automatic bit m_busy(input logic [4:0] s);
    return (cnt_m[s] != 0) && !(wb_valid && wb_dst == s && cnt_m[s] == 1);
  endfunction

  function automatic bit m_stall();
    bit full;
    full = issue_we && issue_dst != 0 && cnt_m[issue_dst] == MAXC &&
           !(wb_valid && wb_dst == issue_dst);
    return issue_valid && (m_busy(src_a) || m_busy(src_b) || full);
  endfunction

  function automatic logic [31:0] m_pend();
    logic [31:0] p = '0;
    for (int i = 1; i < 32; i++) p[i] = (cnt_m[i] != 0);
    return p;
  endfunction

  function automatic int m_sum();
    int s = 0;
    for (int i = 1; i < 32; i++) s += cnt_m[i];
    return s;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) cnt_m[i] = 0;
    err_m = 1'b0;
  endfunction

  // Applies the architectural rules to the current input values.
  function automatic void m_edge();
    bit acc, same;
    acc  = issue_valid && !m_stall() && issue_we && issue_dst != 0;
    same = acc && wb_valid && wb_dst == issue_dst;
    if (wb_valid && wb_dst != 0 && cnt_m[wb_dst] == 0 && !same) err_m = 1'b1;
    if (flush) begin
      for (int i = 0; i < 32; i++) cnt_m[i] = 0;
    end else if (!same) begin
      if (wb_valid && wb_dst != 0 && cnt_m[wb_dst] > 0) cnt_m[wb_dst]--;
      if (acc) cnt_m[issue_dst]++;
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".stall"},    32'(stall),    32'(m_stall()));
    chk({tag, ".busy_a"},   32'(busy_a),   32'(m_busy(src_a)));
    chk({tag, ".busy_b"},   32'(busy_b),   32'(m_busy(src_b)));
    chk({tag, ".pending"},  pending,       m_pend());
    chk({tag, ".inflight"}, 32'(inflight), 32'(m_sum()));
    chk({tag, ".wb_err"},   32'(wb_err),   32'(err_m));
  endtask

  // One cycle: drive at posedge+1, check at posedge+2, advance the model at the edge.
  task automatic step(input string tag, input logic iv, input logic iwe, input logic [4:0] dst,
                      input logic [4:0] sa, input logic [4:0] sb,
                      input logic wbv, input logic [4:0] wbd, input logic fl);
    drive(iv, iwe, dst, sa, sb, wbv, wbd, fl);
    #1;
    check_model(tag);
    @(posedge clk);
    m_edge();
    #1;
  endtask

  vec_t tbl [17];

  initial begin
    // iv iwe dst sa sb wbv wbd fl | stall ba bb | pend infl err (after edge)
    tbl[0]  = '{1,1, 5,1, 2,0, 0,0, 0,0,0, 32'h1 << 5,  8'd1, 0};
    tbl[1]  = '{1,0, 0,5, 0,0, 0,0, 1,1,0, 32'h1 << 5,  8'd1, 0};
    tbl[2]  = '{1,0, 0,5, 0,1, 5,0, 0,0,0, 32'h0,       8'd0, 0};
    tbl[3]  = '{1,1, 9,0, 0,0, 0,0, 0,0,0, 32'h1 << 9,  8'd1, 0};
    tbl[4]  = '{1,1, 9,0, 0,0, 0,0, 0,0,0, 32'h1 << 9,  8'd2, 0};
    tbl[5]  = '{1,1, 9,0, 0,0, 0,0, 0,0,0, 32'h1 << 9,  8'd3, 0};
    tbl[6]  = '{1,1, 9,0, 0,0, 0,0, 1,0,0, 32'h1 << 9,  8'd3, 0};
    tbl[7]  = '{1,1, 9,0, 0,1, 9,0, 0,0,0, 32'h1 << 9,  8'd3, 0};
    tbl[8]  = '{0,0, 0,0, 0,1, 9,0, 0,0,0, 32'h1 << 9,  8'd2, 0};
    tbl[9]  = '{0,0, 0,0, 0,1, 9,0, 0,0,0, 32'h1 << 9,  8'd1, 0};
    tbl[10] = '{0,0, 0,0, 0,1, 9,0, 0,0,0, 32'h0,       8'd0, 0};
    tbl[11] = '{1,1, 0,0, 0,1, 0,0, 0,0,0, 32'h0,       8'd0, 0};
    tbl[12] = '{1,1,12,0, 0,0, 0,0, 0,0,0, 32'h1 << 12, 8'd1, 0};
    tbl[13] = '{1,1, 3,0,12,0, 0,0, 1,0,1, 32'h1 << 12, 8'd1, 0};
    tbl[14] = '{1,1,12,0, 0,1,12,0, 0,0,0, 32'h1 << 12, 8'd1, 0};
    tbl[15] = '{0,0, 0,0, 0,1, 7,0, 0,0,0, 32'h1 << 12, 8'd1, 1};
    tbl[16] = '{0,0, 0,0, 0,0, 0,1, 0,0,0, 32'h0,       8'd0, 1};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset.pending",  pending,       32'h0);
    chk("reset.inflight", 32'(inflight), 32'h0);
    chk("reset.wb_err",   32'(wb_err),   32'h0);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].iv, tbl[i].iwe, tbl[i].dst, tbl[i].sa, tbl[i].sb,
            tbl[i].wbv, tbl[i].wbd, tbl[i].fl);
      #1;
      chk($sformatf("vec%0d.stall", i),  32'(stall),  32'(tbl[i].e_stall));
      chk($sformatf("vec%0d.busy_a", i), 32'(busy_a), 32'(tbl[i].e_ba));
      chk($sformatf("vec%0d.busy_b", i), 32'(busy_b), 32'(tbl[i].e_bb));
      @(posedge clk);
      m_edge();
      #1;
      chk($sformatf("vec%0d.pending", i),  pending,       tbl[i].e_pend);
      chk($sformatf("vec%0d.inflight", i), 32'(inflight), 32'(tbl[i].e_infl));
      chk($sformatf("vec%0d.wb_err", i),   32'(wb_err),   32'(tbl[i].e_err));
    end

    // Flush beats a same-cycle issue.
    step("fl.i3",  1, 1,  3, 0, 0, 0, 0, 0);
    step("fl.i4",  1, 1,  4, 0, 0, 0, 0, 0);
    step("fl.i31", 1, 1, 31, 0, 0, 0, 0, 0);
    step("fl.go",  1, 1,  8, 0, 0, 0, 0, 1);
    chk("flush.pending",  pending,       32'h0);
    chk("flush.inflight", 32'(inflight), 32'h0);
    chk("flush.wb_err",   32'(wb_err),   32'h1);

    // Asynchronous reset between edges with five writes in flight.
    for (int r = 3; r < 8; r++) step("ar.build", 1, 1, 5'(r), 0, 0, 0, 0, 0);
    chk("ar.pre_inflight", 32'(inflight), 32'd5);
    drive(1, 0, 0, 3, 4, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("ar.pending",  pending,       32'h0);
    chk("ar.inflight", 32'(inflight), 32'h0);
    chk("ar.wb_err",   32'(wb_err),   32'h0);
    chk("ar.busy_a",   32'(busy_a),   32'h0);
    chk("ar.stall",    32'(stall),    32'h0);
    m_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        rst_n = 1'b0;
        #1 m_reset();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
      end
      step("rnd",
           ($urandom_range(9, 0) < 7), ($urandom_range(9, 0) < 8),
           5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
           ($urandom_range(1, 0) == 1), 5'($urandom_range(7, 0)),
           ($urandom_range(39, 0) == 0));
    end
    check_model("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
